// File: rtl/rom_load_arbiter.sv
// Program memory arbiter between the HPS download stream and the game CPU.
// Downloads are buffered in a small FIFO; the core is held in reset while loading.
module rom_load_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int ROM_BYTES  = 'hC000,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_HOLD   = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [7:0]        cpu_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              core_reset,
  output logic              dl_done,
  output logic              dl_overflow,
  output logic [ADDR_W-1:0] dl_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {RUN, LOAD, DRAIN, HOLD} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     hold_cnt, hold_nx;
  logic              act_q, loaded, rd_q, done_q, done_nx, ovf_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       fill;
  logic [ADDR_W+7:0] fifo [FIFO_DEPTH];
  logic              rise, in_rom, accept, full, empty;
  logic              pop, push, drop;

  assign rise   = dl_active & ~act_q;
  assign in_rom = int'(dl_addr) < ROM_BYTES;
  assign accept = dl_active & dl_wr & in_rom;
  assign full   = fill == (PW+1)'(FIFO_DEPTH);
  assign empty  = fill == '0;
  assign pop    = (state == LOAD || state == DRAIN) && !empty;
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    done_nx  = 1'b0;
    unique case (state)
      RUN: if (rise) state_nx = LOAD;
      LOAD: if (!dl_active) state_nx = DRAIN;
      DRAIN: begin
        if (rise) begin
          state_nx = LOAD;
        end else if (empty) begin
          state_nx = HOLD;
          hold_nx  = CW'(RST_HOLD);
        end
      end
      HOLD: begin
        if (rise) begin
          state_nx = LOAD;
        end else if (hold_cnt <= CW'(1)) begin
          state_nx = RUN;
          done_nx  = loaded;
        end else begin
          hold_nx = hold_cnt - CW'(1);
        end
      end
      default: state_nx = HOLD;
    endcase
  end

  // act_q resets high so a download already running at reset release
  // is not mistaken for a new one; the host must restart it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HOLD;
      hold_cnt <= CW'(RST_HOLD);
      act_q    <= 1'b1;
      loaded   <= 1'b0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      act_q    <= dl_active;
      loaded   <= loaded | (state_nx == LOAD);
      rd_q     <= mem_re;
      done_q   <= done_nx;
      if (rise) begin
        ovf_q <= drop;
        cnt_q <= push ? ADDR_W'(1) : '0;
      end else begin
        if (drop) ovf_q <= 1'b1;
        if (push) cnt_q <= cnt_q + ADDR_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fill <= fill + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo[wr_ptr] <= {dl_addr, dl_data};
  end

  assign mem_we      = pop;
  assign mem_re      = (state == RUN) && cpu_req;
  assign mem_addr    = pop    ? fifo[rd_ptr][ADDR_W+7:8] :
                       mem_re ? cpu_addr : '0;
  assign mem_din     = pop ? fifo[rd_ptr][7:0] : '0;
  assign cpu_ack     = rd_q;
  assign cpu_data    = rd_q ? mem_dout : '0;
  assign core_reset  = (state != RUN) || rise;
  assign dl_done     = done_q;
  assign dl_overflow = ovf_q;
  assign dl_count    = cnt_q;

endmodule
